adder_avst: RTL and testbench

- Avalon-ST packet summing block.
- Accepts a stream of bytes framed by an end-of-packet flag and sums each packet's bytes modulo 2^WIDTH.
- Emits one single-beat result packet per input packet.
- Sits between an upstream Avalon-ST source and a downstream sink; a small result FIFO decouples the two sides.

---
 rtl/adder_avst.sv | 84 ++++++++
 tb/tb_adder_avst.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_avst.sv
// Avalon-ST packet summer: adds the bytes of each input packet modulo 2^WIDTH
// and queues one single-beat result per packet in a small FIFO.
module adder_avst #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             end_in,
    input  logic             valid_in,
    input  logic             ready_out,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             end_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0] memQ [DEPTH];
    logic [AW-1:0]    wrPtrQ, wrPtrD;
    logic [AW-1:0]    rdPtrQ, rdPtrD;
    logic [CW-1:0]    countQ, countD;
    logic             readyQ;

    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sum;

    assign accept    = valid_in && readyQ;
    assign push      = accept && end_in;
    assign sum       = accQ + data_in;
    assign valid_out = (countQ != '0);
    assign pop       = valid_out && ready_out;
    assign ready_in  = readyQ;
    assign data_out  = valid_out ? memQ[rdPtrQ] : '0;
    assign end_out   = valid_out;

    always_comb begin
        accD   = accQ;
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (accept) begin
            accD = end_in ? '0 : sum;
        end
        if (push) begin
            wrPtrD = wrPtrQ + AW'(1);
        end
        if (pop) begin
            rdPtrD = rdPtrQ + AW'(1);
        end
        countD = countQ + CW'(push) - CW'(pop);
    end

    // ready_in is derived from next occupancy so it stays purely registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            accQ   <= '0;
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
            readyQ <= 1'b0;
        end else begin
            accQ   <= accD;
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
            readyQ <= (countD != FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            memQ[wrPtrQ] <= sum;
        end
    end

endmodule

// File: tb/tb_adder_avst.sv
// Scoreboard bench for adder_avst: directed packets push hand-computed sums,
// an independent monitor pops and compares every output handshake.
module tb_adder_avst;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       end_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_out = 1'b1;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       end_out;

    int checks = 0;
    int errors = 0;
    int outCount = 0;
    logic [7:0] expQ [$];

    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [7:0] prevData = '0;

    adder_avst #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .end_in    (end_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .end_out   (end_out)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectResult(input logic [7:0] val);
        expQ.push_back(val);
    endtask

    task automatic idleCycles(input int n, input logic [7:0] junkData, input logic junkEnd);
        valid_in = 1'b0;
        data_in  = junkData;
        end_in   = junkEnd;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the beat until it is seen accepted (ready_in high before an edge)
    task automatic sendBeat(input logic [7:0] d, input logic e);
        int   tries;
        logic took;
        tries    = 0;
        took     = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        end_in   = e;
        do begin
            @(negedge clk);
            took = ready_in;
            @(posedge clk);
            #1;
            tries++;
        end while (!took && tries < 200);
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: beat 0x%0h not accepted, expected acceptance", d);
        end
        valid_in = 1'b0;
        data_in  = 'x;
        end_in   = 1'bx;
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while ((expQ.size() != 0 || valid_out) && tries < 200) begin
            @(posedge clk);
            #1;
            tries++;
        end
        checkVal("drain_pending", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (prevValid && !prevReady) begin
                checkVal("hold_valid", valid_out, 1);
                checkVal("hold_data", data_out, prevData);
            end
            if (!valid_out && (data_out !== 8'h00 || end_out !== 1'b0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL idle_outputs: data 0x%0h end %0b, expected 0 and 0", data_out, end_out);
            end
            if (valid_out && ready_out) begin
                outCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no result", data_out);
                end else begin
                    checkVal("result_data", data_out, expQ.pop_front());
                    checkVal("result_end", end_out, 1);
                end
            end
            prevValid = valid_out;
            prevReady = ready_out;
            prevData  = data_out;
        end else begin
            prevValid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int startCount;

        // Reset held for five cycles, then released
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkVal("rst_ready_in", ready_in, 0);
        checkVal("rst_valid_out", valid_out, 0);
        checkVal("rst_data_out", data_out, 0);
        checkVal("rst_end_out", end_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("post_rst_ready_in", ready_in, 1);
        checkVal("post_rst_valid_out", valid_out, 0);
        @(posedge clk);
        #1;

        // Single three-beat packet
        startCount = outCount;
        expectResult(8'h06);
        sendBeat(8'h01, 1'b0);
        sendBeat(8'h02, 1'b0);
        sendBeat(8'h03, 1'b1);
        drain();
        idleCycles(2, 8'h00, 1'b0);
        checkVal("single_pkt_beats", outCount - startCount, 1);

        // Wrap-around and single-beat packet, back to back
        expectResult(8'h01);
        sendBeat(8'hFF, 1'b0);
        sendBeat(8'h02, 1'b1);
        expectResult(8'h7A);
        sendBeat(8'h7A, 1'b1);
        drain();

        // Idle gaps with junk on data/end while valid_in is low
        expectResult(8'h30);
        sendBeat(8'h10, 1'b0);
        idleCycles(3, 8'hFF, 1'b1);
        idleCycles(2, 8'hxx, 1'bx);
        sendBeat(8'h20, 1'b1);
        drain();

        // Backpressure: fill the FIFO with four results
        ready_out = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expectResult(8'(i));
            sendBeat(8'(i), 1'b1);
        end
        @(negedge clk);
        checkVal("bp_ready_in_low", ready_in, 0);
        checkVal("bp_head_data", data_out, 8'h01);
        checkVal("bp_head_valid", valid_out, 1);
        repeat (3) @(negedge clk);
        checkVal("bp_still_full", ready_in, 0);
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        expectResult(8'h05);
        sendBeat(8'h05, 1'b1);
        drain();

        // Reset in the middle of a packet discards the partial sum
        sendBeat(8'h05, 1'b0);
        sendBeat(8'h06, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        expectResult(8'h01);
        sendBeat(8'h01, 1'b1);
        drain();

        idleCycles(3, 8'h00, 1'b0);
        checkVal("final_valid_out", valid_out, 0);
        checkVal("final_queue", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
